am2950: RTL and testbench

AM2950 -- requirements
Module: am2950

---
 rtl/am2950_pkg.sv | 13 +
 rtl/am2950_chan.sv | 62 ++++++
 rtl/am2950.sv | 58 +++++
 tb/tb_am2950.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/am2950_pkg.sv
// Shared types and constants for the AM2950 bidirectional bus transceiver slice.
// Holds the per-channel flag state encoding and the default data width.
package am2950_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FULL    = 2'd1,
        OVERRUN = 2'd2
    } flag_state_t;

endpackage

// File: rtl/am2950_chan.sv
// One transfer channel: WIDTH-bit register, EMPTY/FULL(/OVERRUN) flag FSM, tristate driver.
// Latency: loaded data is on dout right after the capturing edge; flag follows one edge after ld_/clr_.
// Backpressure: none; a load while FULL overwrites (and marks OVERRUN when AM2950_OVERRUN_EN is defined).
module am2950_chan
    import am2950_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             ld_,
    input  logic             clr_,
    input  logic             oe_,
    inout  wire  [WIDTH-1:0] dout,
    output logic             flag
`ifdef AM2950_OVERRUN_EN
    ,
    output logic             ovf
`endif
);

    flag_state_t      state_q;
    flag_state_t      state_d;
    logic [WIDTH-1:0] data_q;

    // Load beats clear; clear only acts when no load is requested this edge.
    always_comb begin
        state_d = state_q;
        if (!ld_) begin
`ifdef AM2950_OVERRUN_EN
            state_d = (state_q == EMPTY) ? FULL : OVERRUN;
`else
            state_d = FULL;
`endif
        end else if (!clr_) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (!ld_) begin
                data_q <= din;
            end
        end
    end

    assign flag = (state_q != EMPTY);

`ifdef AM2950_OVERRUN_EN
    assign ovf = (state_q == OVERRUN);
`endif

    // The driver stays combinational on oe_, including while rst is held.
    assign dout = oe_ ? {WIDTH{1'bz}} : data_q;

endmodule

// File: rtl/am2950.sv
// AM2950 transceiver: R channel carries a -> b, S channel carries b -> a, each with a consumer flag.
// Latency: bus shows new data right after the load edge; fr/fs change one edge after load/clear.
// Backpressure: none; AM2950_OVERRUN_EN adds ovr/ovs to report loads onto unconsumed data.
module am2950
    import am2950_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] a,
    inout  wire  [WIDTH-1:0] b,
    input  logic             cer_,
    input  logic             ces_,
    input  logic             oeb_,
    input  logic             oea_,
    input  logic             clrr_,
    input  logic             clrs_,
    output logic             fr,
    output logic             fs
`ifdef AM2950_OVERRUN_EN
    ,
    output logic             ovr,
    output logic             ovs
`endif
);

    am2950_chan #(.WIDTH(WIDTH)) u_r (
        .clk  (clk),
        .rst  (rst),
        .din  (a),
        .ld_  (cer_),
        .clr_ (clrr_),
        .oe_  (oeb_),
        .dout (b),
        .flag (fr)
`ifdef AM2950_OVERRUN_EN
        ,
        .ovf  (ovr)
`endif
    );

    am2950_chan #(.WIDTH(WIDTH)) u_s (
        .clk  (clk),
        .rst  (rst),
        .din  (b),
        .ld_  (ces_),
        .clr_ (clrs_),
        .oe_  (oea_),
        .dout (a),
        .flag (fs)
`ifdef AM2950_OVERRUN_EN
        ,
        .ovf  (ovs)
`endif
    );

endmodule

// File: tb/tb_am2950.sv
// Self-checking bench for am2950: directed scenarios plus randomized traffic against a reference model.
// Undriven buses are pulled high, so a released bus reads all ones.
module tb_am2950;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cer_, ces_, oeb_, oea_, clrr_, clrs_;
    logic         fr, fs;
`ifdef AM2950_OVERRUN_EN
    logic         ovr, ovs;
`endif
    wire  [W-1:0] a;
    wire  [W-1:0] b;
    logic [W-1:0] a_drv, b_drv;
    logic         a_en, b_en;

    int n_pass  = 0;
    int n_total = 0;

    assign a = a_en ? a_drv : {W{1'bz}};
    assign b = b_en ? b_drv : {W{1'bz}};

    for (genvar i = 0; i < W; i++) begin : g_pu
        pullup pu_a (a[i]);
        pullup pu_b (b[i]);
    end

    always #5 clk = ~clk;

    am2950 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .cer_  (cer_),
        .ces_  (ces_),
        .oeb_  (oeb_),
        .oea_  (oea_),
        .clrr_ (clrr_),
        .clrs_ (clrs_),
        .fr    (fr),
        .fs    (fs)
`ifdef AM2950_OVERRUN_EN
        ,
        .ovr   (ovr),
        .ovs   (ovs)
`endif
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; cer_ = 1'b1; ces_ = 1'b1; clrr_ = 1'b1; clrs_ = 1'b1;
        oeb_ = 1'b1; oea_ = 1'b1; a_en = 1'b0; b_en = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; cer_ = 1'b0; ces_ = 1'b0; clrr_ = 1'b0; clrs_ = 1'b0;
        oeb_ = 1'b0; oea_ = 1'b0;
        tick();
        #1;
        n_total++; if (fr !== 1'b0) $display("FAIL reset_fr got %b want 0", fr); else n_pass++;
        n_total++; if (fs !== 1'b0) $display("FAIL reset_fs got %b want 0", fs); else n_pass++;
        n_total++; if (b !== 8'h00) $display("FAIL reset_b got %h want 00", b); else n_pass++;
        n_total++; if (a !== 8'h00) $display("FAIL reset_a got %h want 00", a); else n_pass++;
`ifdef AM2950_OVERRUN_EN
        n_total++; if (ovr !== 1'b0 || ovs !== 1'b0) $display("FAIL reset_ov got %b%b want 00", ovr, ovs); else n_pass++;
`endif
        idle();
        tick();
    endtask

    task automatic test_a_to_b();
        idle();
        a_en = 1'b1; a_drv = 8'h33; cer_ = 1'b0; oeb_ = 1'b0;
        tick();
        cer_ = 1'b1; a_en = 1'b0;
        #1;
        n_total++; if (fr !== 1'b1) $display("FAIL a2b_fr got %b want 1", fr); else n_pass++;
        n_total++; if (b !== 8'h33) $display("FAIL a2b_b got %h want 33", b); else n_pass++;
        clrr_ = 1'b0;
        tick();
        clrr_ = 1'b1;
        #1;
        n_total++; if (fr !== 1'b0) $display("FAIL a2b_clr_fr got %b want 0", fr); else n_pass++;
        n_total++; if (b !== 8'h33) $display("FAIL a2b_clr_b got %h want 33", b); else n_pass++;
        idle();
    endtask

    task automatic test_b_to_a();
        idle();
        b_en = 1'b1; b_drv = 8'hAA; ces_ = 1'b0; oea_ = 1'b0;
        tick();
        ces_ = 1'b1; b_en = 1'b0;
        #1;
        n_total++; if (fs !== 1'b1) $display("FAIL b2a_fs got %b want 1", fs); else n_pass++;
        n_total++; if (a !== 8'hAA) $display("FAIL b2a_a got %h want aa", a); else n_pass++;
        oea_ = 1'b1;
        #1;
        n_total++; if (a !== 8'hFF) $display("FAIL b2a_hiz got %h want ff (released)", a); else n_pass++;
        clrs_ = 1'b0;
        tick();
        idle();
    endtask

    task automatic test_load_clear();
        idle();
        a_en = 1'b1; a_drv = 8'hF0; cer_ = 1'b0; clrr_ = 1'b0;
        tick();
        idle(); oeb_ = 1'b0;
        #1;
        n_total++; if (fr !== 1'b1) $display("FAIL ldclr_fr got %b want 1", fr); else n_pass++;
        n_total++; if (b !== 8'hF0) $display("FAIL ldclr_r got %h want f0", b); else n_pass++;
        clrr_ = 1'b0;
        tick();
        idle();
    endtask

    task automatic test_overrun();
        idle();
        a_en = 1'b1; a_drv = 8'h55; cer_ = 1'b0;
        tick();
        a_drv = 8'h0F;
        tick();
        idle(); oeb_ = 1'b0;
        #1;
        n_total++; if (fr !== 1'b1) $display("FAIL ovr_fr got %b want 1", fr); else n_pass++;
        n_total++; if (b !== 8'h0F) $display("FAIL ovr_b got %h want 0f", b); else n_pass++;
`ifdef AM2950_OVERRUN_EN
        n_total++; if (ovr !== 1'b1) $display("FAIL ovr_set got %b want 1", ovr); else n_pass++;
`endif
        clrr_ = 1'b0;
        tick();
        clrr_ = 1'b1;
        #1;
        n_total++; if (fr !== 1'b0) $display("FAIL ovr_clr_fr got %b want 0", fr); else n_pass++;
`ifdef AM2950_OVERRUN_EN
        n_total++; if (ovr !== 1'b0) $display("FAIL ovr_clr got %b want 0", ovr); else n_pass++;
`endif
        idle();
    endtask

    task automatic test_mid_reset();
        idle();
        b_en = 1'b1; b_drv = 8'hCC; ces_ = 1'b0;
        tick();
        rst = 1'b1; b_drv = 8'h33;
        tick();
        idle(); oea_ = 1'b0;
        #1;
        n_total++; if (fs !== 1'b0) $display("FAIL midrst_fs got %b want 0", fs); else n_pass++;
        n_total++; if (a !== 8'h00) $display("FAIL midrst_s got %h want 00", a); else n_pass++;
        idle();
    endtask

    task automatic test_self_loop();
        idle();
        b_en = 1'b1; b_drv = 8'h3C; ces_ = 1'b0;
        tick();
        idle(); oea_ = 1'b0; cer_ = 1'b0;
        tick();
        idle(); oeb_ = 1'b0;
        #1;
        n_total++; if (fr !== 1'b1) $display("FAIL loop_fr got %b want 1", fr); else n_pass++;
        n_total++; if (b !== 8'h3C) $display("FAIL loop_r got %h want 3c", b); else n_pass++;
        clrr_ = 1'b0; clrs_ = 1'b0;
        tick();
        idle();
    endtask

    task automatic test_random();
        logic [W-1:0] m_r = '0, m_s = '0;
        logic         m_rf = 1'b0, m_sf = 1'b0, m_ro = 1'b0, m_so = 1'b0;
        int           errs = 0;
        idle();
        rst = 1'b1;
        tick();
        for (int it = 0; it < 300; it++) begin
            idle();
            rst   = ($urandom_range(0, 19) == 0);
            cer_  = $urandom_range(0, 1);
            ces_  = $urandom_range(0, 1);
            clrr_ = $urandom_range(0, 1);
            clrs_ = $urandom_range(0, 1);
            a_en = 1'b1; a_drv = W'($urandom);
            b_en = 1'b1; b_drv = W'($urandom);
            if (rst) begin
                m_r = '0; m_s = '0; m_rf = 0; m_sf = 0; m_ro = 0; m_so = 0;
            end else begin
                if (!cer_) begin
`ifdef AM2950_OVERRUN_EN
                    if (m_rf) m_ro = 1'b1;
`endif
                    m_r = a_drv; m_rf = 1'b1;
                end else if (!clrr_) begin
                    m_rf = 1'b0; m_ro = 1'b0;
                end
                if (!ces_) begin
`ifdef AM2950_OVERRUN_EN
                    if (m_sf) m_so = 1'b1;
`endif
                    m_s = b_drv; m_sf = 1'b1;
                end else if (!clrs_) begin
                    m_sf = 1'b0; m_so = 1'b0;
                end
            end
            tick();
            idle(); oea_ = 1'b0; oeb_ = 1'b0;
            #1;
            n_total++;
            if (fr !== m_rf || fs !== m_sf || b !== m_r || a !== m_s) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL rand_%0d got fr=%b fs=%b b=%h a=%h want fr=%b fs=%b b=%h a=%h",
                             it, fr, fs, b, a, m_rf, m_sf, m_r, m_s);
            end else n_pass++;
`ifdef AM2950_OVERRUN_EN
            n_total++;
            if (ovr !== m_ro || ovs !== m_so)
                $display("FAIL rand_ov_%0d got %b%b want %b%b", it, ovr, ovs, m_ro, m_so);
            else n_pass++;
`endif
            tick();
        end
        idle();
    endtask

    initial begin
        a_drv = '0; b_drv = '0;
        idle();
        @(negedge clk);
        test_reset();
        test_a_to_b();
        test_b_to_a();
        test_load_clear();
        test_overrun();
        test_mid_reset();
        test_self_loop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
